// File: rtl/ekf_stage_sched_if.sv
// ekf_stage_sched_if: handshake bundle between the EKF stage scheduler and its command source, the RSA core and the nonlinear unit
// master: scheduler side, drives cmd_rdy, landmark_num, l_k, stage_val, nonlinear_s_val/rdy, nl_start, nl_stage, busy, cmd_err
// slave:  environment side, drives cmd_val, cmd_stage, cmd_lk, stage_rdy, nonlinear_m_val/rdy, nl_done
interface ekf_stage_sched_if #(parameter int ROW_LEN = 10);
  logic               cmd_val;
  logic               cmd_rdy;
  logic [2:0]         cmd_stage;
  logic [ROW_LEN-1:0] cmd_lk;
  logic [ROW_LEN-1:0] landmark_num;
  logic [ROW_LEN-1:0] l_k;
  logic [2:0]         stage_val;
  logic [2:0]         stage_rdy;
  logic [2:0]         nonlinear_m_val;
  logic [2:0]         nonlinear_m_rdy;
  logic [2:0]         nonlinear_s_val;
  logic [2:0]         nonlinear_s_rdy;
  logic               nl_start;
  logic [2:0]         nl_stage;
  logic               nl_done;
  logic               busy;
  logic               cmd_err;
  modport master (
    input  cmd_val, cmd_stage, cmd_lk, stage_rdy, nonlinear_m_val, nonlinear_m_rdy, nl_done,
    output cmd_rdy, landmark_num, l_k, stage_val, nonlinear_s_val, nonlinear_s_rdy, nl_start, nl_stage, busy, cmd_err
  );
  modport slave (
    output cmd_val, cmd_stage, cmd_lk, stage_rdy, nonlinear_m_val, nonlinear_m_rdy, nl_done,
    input  cmd_rdy, landmark_num, l_k, stage_val, nonlinear_s_val, nonlinear_s_rdy, nl_start, nl_stage, busy, cmd_err
  );
endinterface

// File: rtl/ekf_stage_sched.sv
// ekf_stage_sched: sequences one EKF stage (PRD/NEW/UPD) at a time through the RSA and brokers its nonlinear round trip
// Ports: clk, sys_rst_n (async, active low), bus (ekf_stage_sched_if.master: command, RSA stage/nonlinear handshakes,
//   nonlinear unit start/done, landmark_num/l_k registers, busy, cmd_err).
// Optional: STAGE_WDT_EN adds a WDT_W-bit per-state watchdog that aborts a stalled stage back to IDLE with cmd_err.
module ekf_stage_sched #(
  parameter int ROW_LEN = 10,
  parameter int MAX_LM  = 500
`ifdef STAGE_WDT_EN
  , parameter int WDT_W = 16
`endif
) (
  input logic clk,
  input logic sys_rst_n,
  ekf_stage_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_NLM, NL_RUN, NL_RET, WAIT_DONE} state_t;
  localparam logic [2:0] PRD = 3'b001, NEW = 3'b010, UPD = 3'b100;
  state_t state_q, state_d;
  logic [2:0] cur_q, cur_d;
  logic [ROW_LEN-1:0] landmark_num_q, landmark_num_d, l_k_q, l_k_d;
  logic nl_start_q, nl_start_d, cmd_err_q, cmd_err_d;
  logic legal, wdt_hit;
  // NEW at a full landmark table is rejected, so landmark_num can never wrap
  assign legal = bus.cmd_stage == PRD || bus.cmd_stage == UPD ||
                 (bus.cmd_stage == NEW && landmark_num_q != ROW_LEN'(MAX_LM));
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    landmark_num_d = landmark_num_q;
    l_k_d = l_k_q;
    nl_start_d = 1'b0;
    cmd_err_d = 1'b0;
    case (state_q)
      IDLE:
        if (bus.cmd_val) begin
          if (legal) begin
            cur_d = bus.cmd_stage;
            l_k_d = bus.cmd_stage == UPD ? bus.cmd_lk : bus.cmd_stage == NEW ? landmark_num_q : l_k_q;
            state_d = ISSUE;
          end else cmd_err_d = 1'b1;
        end
      ISSUE:     if (|(bus.stage_rdy & cur_q)) state_d = WAIT_NLM;
      WAIT_NLM:
        if (|(bus.nonlinear_m_val & cur_q)) begin
          state_d = NL_RUN;
          nl_start_d = 1'b1;
        end
      NL_RUN:    if (bus.nl_done) state_d = NL_RET;
      NL_RET:    if (|(bus.nonlinear_m_rdy & cur_q)) state_d = WAIT_DONE;
      WAIT_DONE:
        if (|(bus.stage_rdy & cur_q)) begin
          state_d = IDLE;
          landmark_num_d = cur_q == NEW ? landmark_num_q + 1'b1 : landmark_num_q;
        end
      default:   state_d = IDLE;
    endcase
    if (wdt_hit) begin
      state_d = IDLE;
      landmark_num_d = landmark_num_q;
      nl_start_d = 1'b0;
      cmd_err_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cur_q <= 3'b000;
      landmark_num_q <= '0;
      l_k_q <= '0;
      nl_start_q <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      landmark_num_q <= landmark_num_d;
      l_k_q <= l_k_d;
      nl_start_q <= nl_start_d;
      cmd_err_q <= cmd_err_d;
    end
`ifdef STAGE_WDT_EN
  logic [WDT_W-1:0] wdt_q, wdt_d;
  assign wdt_hit = &wdt_q;
  // counts cycles spent in the current non-IDLE state
  assign wdt_d = (state_d != state_q || state_q == IDLE) ? '0 : wdt_q + 1'b1;
  always_ff @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) wdt_q <= '0;
    else wdt_q <= wdt_d;
`else
  assign wdt_hit = 1'b0;
`endif
  assign bus.cmd_rdy = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.stage_val = state_q == ISSUE && !wdt_hit ? cur_q : 3'b000;
  assign bus.nonlinear_s_rdy = state_q == WAIT_NLM && !wdt_hit ? cur_q : 3'b000;
  assign bus.nl_stage = state_q == NL_RUN && !wdt_hit ? cur_q : 3'b000;
  assign bus.nonlinear_s_val = state_q == NL_RET && !wdt_hit ? cur_q : 3'b000;
  assign bus.nl_start = nl_start_q;
  assign bus.cmd_err = cmd_err_q;
  assign bus.landmark_num = landmark_num_q;
  assign bus.l_k = l_k_q;
endmodule
